// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: time-multiplexes a DIGITS-wide BCD value onto one 7-segment decoder.
// Loads commit only at frame boundaries. Define BCD_SCAN_LZB_EN for leading-zero blanking.

module bcd_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic [3:0]          y,
    output logic [DIGITS-1:0]   an
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int IDX_W = ($clog2(DIGITS) < 1) ? 1 : $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_shadow;
    logic [4*DIGITS-1:0] r_active;
    logic [DIGITS-1:0]   r_an;
    logic [3:0]          r_y;

    logic                w_tick;
    logic                w_frame_end;
    logic                w_accept;
    logic                w_blank;
    logic [3:0]          w_raw;
    logic [3:0]          w_digit;

    assign w_tick      = (r_cnt == CNT_LAST);
    assign w_frame_end = w_tick && (r_idx == IDX_LAST);
    assign w_accept    = in_valid && !r_pending;
    assign w_blank     = (r_cnt < CNT_BLANK);
    assign w_raw       = r_active[4*r_idx +: 4];

    assign in_ready = ~r_pending;
    assign an       = r_an;
    assign y        = r_y;

`ifdef BCD_SCAN_LZB_EN
    // Bit i is set when digit i and every higher digit are zero.
    logic [DIGITS-1:0] w_zero_above;

    // NOTE: always_comb assigns every output a default before any branch, so no latch is inferred.
    always_comb begin
        w_zero_above             = '0;
        w_zero_above[DIGITS-1]   = (r_active[4*(DIGITS-1) +: 4] == 4'h0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            w_zero_above[i] = w_zero_above[i+1] && (r_active[4*i +: 4] == 4'h0);
        end
    end

    // Digit 0 always shows, so a zero value still displays a single "0".
    assign w_digit = ((r_idx != '0) && w_zero_above[r_idx]) ? 4'hF : w_raw;
`else
    assign w_digit = w_raw;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Accept and commit are exclusive: accepting needs pending clear, committing needs it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_shadow  <= '0;
            r_active  <= {DIGITS{4'hF}};
        end else if (w_frame_end && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_shadow  <= bcd_in;
            r_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an <= '1;
            r_y  <= 4'hF;
        end else if (w_blank) begin
            r_an <= '1;
            r_y  <= 4'hF;
        end else begin
            r_an <= ~(DIGITS'(1) << r_idx);
            r_y  <= w_digit;
        end
    end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Self-checking bench for bcd_scan_driver (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2).
// Expected frame contents are queued at load time and compared as each frame is scanned.

module tb_bcd_scan_driver;

    localparam int DIGITS = 4;
    localparam int SLOT   = 8;
    localparam int FRAME  = SLOT * DIGITS;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] bcd_in   = '0;
    logic        in_ready;
    logic [3:0]  y;
    logic [3:0]  an;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    bcd_scan_driver #(
        .DIGITS      (DIGITS),
        .PRESCALE    (SLOT),
        .BLANK_CYCLES(2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .bcd_in  (bcd_in),
        .y       (y),
        .an      (an)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // cyc counts rising edges since reset release; outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        bcd_in   = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        exp_q.delete();
    endtask

    // Presents a value for one edge, then scrambles bcd_in since it need not be held.
    task automatic drive_load(input logic [15:0] v);
        in_valid = 1'b1;
        bcd_in   = v;
        step();
        in_valid = 1'b0;
        bcd_in   = 16'hDEAD;
    endtask

    task automatic check_ready(input string name, input logic exp);
        checks++;
        if (in_ready !== exp) begin
            errors++;
            $display("FAIL %s: in_ready=%b expected %b (cyc %0d)", name, in_ready, exp, cyc);
        end
    endtask

    // Pops the expected contents of frame f and checks each slot's blank and lit phases.
    task automatic check_frame(input int f);
        logic [15:0] exp;
        logic [3:0]  exp_an;
        int          blank_c;
        int          show_c;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected value for frame %0d", f);
            return;
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < DIGITS; i++) begin
            blank_c = f * FRAME + i * SLOT + 1;
            show_c  = blank_c + 2;
            exp_an  = ~(4'b0001 << i);
            if (blank_c >= cyc) begin
                wait_until(blank_c);
                checks++;
                if (an !== 4'hF || y !== 4'hF) begin
                    errors++;
                    $display("FAIL frame%0d_slot%0d_blank: an=%b y=%h expected an=1111 y=f",
                             f, i, an, y);
                end
            end
            if (show_c >= cyc) begin
                wait_until(show_c);
                checks++;
                if (an !== exp_an || y !== exp[4*i +: 4]) begin
                    errors++;
                    $display("FAIL frame%0d_slot%0d_digit: an=%b y=%h expected an=%b y=%h",
                             f, i, an, y, exp_an, exp[4*i +: 4]);
                end
            end
        end
    endtask

    task automatic test_reset();
        int         c;
        int         s;
        logic [3:0] exp_an;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || y !== 4'hF || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: an=%b y=%h in_ready=%b expected 1111 f 1", an, y, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            c      = (k - 1) % SLOT;
            s      = ((k - 1) / SLOT) % DIGITS;
            exp_an = (c < 2) ? 4'hF : ~(4'b0001 << s);
            checks++;
            if (an !== exp_an || y !== 4'hF || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_rotation: cyc %0d an=%b y=%h rdy=%b expected an=%b y=f rdy=1",
                         k, an, y, in_ready, exp_an);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        exp_q.push_back(16'hFFFF);
        wait_until(4);
        exp_q.push_back(16'h1234);
        drive_load(16'h1234);
        check_ready("load_ready_low", 1'b0);
        check_frame(0);
        wait_until(31);
        check_ready("load_ready_before_frame_end", 1'b0);
        wait_until(32);
        check_ready("load_ready_after_frame_end", 1'b1);
        check_frame(1);
    endtask

    task automatic test_back_to_back();
        do_reset();
        exp_q.push_back(16'hFFFF);
        wait_until(4);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h1234);
        drive_load(16'h1234);
        in_valid = 1'b1;
        bcd_in   = 16'h5678;
        check_frame(0);
        wait_until(31);
        check_ready("hold_ready_low", 1'b0);
        wait_until(32);
        check_ready("hold_ready_rises", 1'b1);
        in_valid = 1'b0;
        check_frame(1);
        check_frame(2);
    endtask

    task automatic test_frame_end_load();
        do_reset();
        exp_q.push_back(16'hFFFF);
        check_frame(0);
        wait_until(31);
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'h9999);
        drive_load(16'h9999);
        check_ready("frame_end_accept", 1'b0);
        check_frame(1);
        wait_until(63);
        check_ready("frame_end_pending", 1'b0);
        wait_until(64);
        check_ready("frame_end_commit", 1'b1);
        check_frame(2);
    endtask

    task automatic test_async_reset();
        do_reset();
        exp_q.push_back(16'hFFFF);
        wait_until(4);
        drive_load(16'h4321);
        check_frame(0);
        wait_until(33);
        drive_load(16'h8765);
        check_ready("pre_reset_pending", 1'b0);
        wait_until(35);
        checks++;
        if (an !== 4'b1110 || y !== 4'h1) begin
            errors++;
            $display("FAIL pre_reset_slot0: an=%b y=%h expected an=1110 y=1", an, y);
        end
        wait_until(53);
        checks++;
        if (an !== 4'b1011 || y !== 4'h3) begin
            errors++;
            $display("FAIL pre_reset_slot2: an=%b y=%h expected an=1011 y=3", an, y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || y !== 4'hF || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: an=%b y=%h in_ready=%b expected 1111 f 1", an, y, in_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        exp_q.delete();
        exp_q.push_back(16'hFFFF);
        exp_q.push_back(16'hFFFF);
        check_ready("post_reset_ready", 1'b1);
        check_frame(0);
        check_frame(1);
    endtask

    task automatic test_leading_zero();
        do_reset();
        exp_q.push_back(16'hFFFF);
        wait_until(4);
`ifdef BCD_SCAN_LZB_EN
        exp_q.push_back(16'hFF70);
`else
        exp_q.push_back(16'h0070);
`endif
        drive_load(16'h0070);
        check_frame(0);
        wait_until(32);
`ifdef BCD_SCAN_LZB_EN
        exp_q.push_back(16'hFFF0);
`else
        exp_q.push_back(16'h0000);
`endif
        drive_load(16'h0000);
        check_frame(1);
        check_frame(2);
        wait_until(64);
        check_ready("non_bcd_ready", 1'b1);
        exp_q.push_back(16'hA0C0);
        drive_load(16'hA0C0);
        check_frame(3);
    endtask

    initial begin
        test_reset();
        test_load();
        test_back_to_back();
        test_frame_end_load();
        test_async_reset();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_scan_driver.md
Name: bcd_scan_driver

Overview:
- Upstream feeder for the 7-segment BCD decoder.
- Holds a multi-digit BCD value and time-multiplexes it one digit at a time: 4-bit digit code `y` goes to the decoder, active-low `an` goes to the anodes.
- Provides a valid/ready load handshake. New values commit only at a scan-frame boundary, so a frame never shows a mix of old and new digits.
- Includes anti-ghost blanking between digits.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 100000, clk cycles per digit slot (≥ 4).
- BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (1 ≤ BLANK_CYCLES < PRESCALE).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  bcd_in holds a new display value.
- in_ready  output  1  block can accept a value this cycle.
- bcd_in  input  4*DIGITS  BCD digits; digit 0 is bits [3:0] (rightmost).
- y  output  4  digit code to decoder; 4'hF means blank.
- an  output  DIGITS  anode enables, active-low; an[i] drives digit i.

Behaviour:
- **Interface (decided):** one clock `clk`; reset `rst_n` is asynchronous, active-low.
- **Reset values:**
  - cnt=0, idx=0, pending=0, shadow=0.
  - active = all nibbles 4'hF.
  - an = all ones, y = 4'hF, in_ready = 1 (combinational from pending).
- **Prescaler cnt:** counts 0..PRESCALE-1 and wraps to 0.
  - tick = (cnt == PRESCALE-1).
- **Digit index idx:** advances on tick; wraps DIGITS-1 → 0.
  - frame_end = tick && idx == DIGITS-1.
- **Outputs:** an and y are registered every cycle from current (cnt, idx, active); latency 1 cycle.
  - If cnt < BLANK_CYCLES: an = all ones, y = 4'hF.
  - Otherwise: an = one-cold with bit idx = 0; y = active[4*idx +: 4].
- **Handshake:** in_ready = ~pending.
  - Accept when in_valid && in_ready: shadow ← bcd_in, pending ← 1.
  - bcd_in is ignored while in_ready = 0 and is not required to be held.
- **Commit:** on frame_end with pending=1: active ← shadow, pending ← 0.
  - The new value appears from slot 0 of the next frame.
- **Same-cycle accept and frame_end:** only possible with pending=0. Shadow loads and pending sets; that value commits at the following frame_end, never the current one.
- **Same-cycle frame_end and pending=1:** commit happens; in_ready returns to 1 next cycle. Back-to-back loads are therefore limited to one per frame.
- **Non-BCD nibbles (A–F):** passed through unchanged; the decoder shows them blank.
- **Reset asserted mid-frame or mid-handshake:** all state returns to reset values immediately. Any pending value is discarded.
- **Widths:**
  - cnt is $clog2(PRESCALE) bits; idx is $clog2(DIGITS) bits, minimum 1.
  - No arithmetic on digit data.

Optional Feature:
- Macro: BCD_SCAN_LZB_EN (leading-zero blanking).
- **Defined:** for the digit being driven, if it and every higher-index active digit equal 4'h0, y = 4'hF instead of 4'h0.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - an timing is unchanged: the anode still pulses, showing a blank.
- **Undefined:** all digits are shown as stored, including leading zeros.

Test Plan (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless noted):
- **Reset release:** no loads → an=4'b1111, y=4'hF for 3 cycles. Then an=4'b1110, y=4'hF for 6 cycles, an=4'b1101 slot next; full rotation 1110→1101→1011→0111→1110 with 8-cycle slots.
- **Load 16'h1234 at cycle 5:** in_ready=0 from cycle 6 until 1 cycle after frame_end. Next frame shows y=4, 3, 2, 1 on an=1110, 1101, 1011, 0111. The current frame keeps all-blank.
- **Load 16'h5678 held valid while in_ready=0:** only the first accepted value is displayed; in_ready rises exactly 1 cycle after frame_end.
- **Load coinciding with frame_end:** 16'h9999 asserted in the frame_end cycle with pending=0 → accepted; displayed one full frame later, not in the immediately following frame.
- **Async reset mid-slot:** display 16'h4321, drop rst_n mid-slot 2 → an=1111, y=F within the same cycle (async). After release, the rotation restarts at slot 0 blank.
- **With BCD_SCAN_LZB_EN:**
  - Load 16'h0070 → y=0, 7, F, F.
  - Load 16'h0000 → y=0, F, F, F.
  - Without the macro: 16'h0070 → y=0, 7, 0, 0.
